// File: rtl/serial_capture.sv
`default_nettype none
// ============================================================================
// Module   : serial_capture
// Purpose  : 8N1 serial receiver that writes tagged bytes into character RAM.
// Revision : 1.0
// ============================================================================

module serial_capture #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int ADDR_W       = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx,
    input  logic              clear,
    output logic [15:0]       data_out,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              full,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_m1  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;
    localparam logic [2:0] c_st_break = 3'd5;

    logic [1:0]        r_sync;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [15:0]       r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_full;
    logic              r_frame_err;
    logic              w_rx_s;
    logic              w_we;

    assign w_rx_s = r_sync[1];

    // Synchroniser keeps running through clear so the line state stays current.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Strobe is combinational so a same-cycle clear or reset can still veto it.
    assign w_we = (r_state == c_st_write) && !r_full && !clear && !reset;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (clear) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (r_cnt == c_half_m1) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? c_st_idle : c_st_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (r_cnt == c_bit_m1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_st_stop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    if (r_cnt == c_bit_m1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= c_st_write;
                            // A full buffer must not disturb the last written word.
                            if (!r_full) begin
                                r_data <= {1'b1, 7'b0, r_shift};
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_st_break;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_write: begin
                    r_state <= c_st_idle;
                    if (!r_full) begin
                        r_addr <= r_addr + 1'b1;
                        if (&r_addr) begin
                            r_full <= 1'b1;
                        end
                    end
                end
                c_st_break: begin
                    if (w_rx_s) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign we        = w_we;
    assign addr      = r_addr;
    assign full      = r_full;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_serial_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_capture
// Purpose  : Directed self-checking bench for serial_capture (16 clks/bit).
// Revision : 1.0
// ============================================================================

module tb_serial_capture;

    localparam int CLKS = 16;

    logic        sysclk;
    logic        reset;
    logic        rx;
    logic        clear;
    logic [15:0] data_out;
    logic        we;
    logic [7:0]  addr;
    logic        full;
    logic        frame_err;
    logic        busy;

    logic        rx2;
    logic        clear2;
    logic [15:0] data_out2;
    logic        we2;
    logic [1:0]  addr2;
    logic        full2;
    logic        frame_err2;
    logic        busy2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_start  = 0;

    logic [15:0] wr_data [16];
    logic [7:0]  wr_addr [16];
    int          wr_cyc  [16];
    int          n_wr = 0;
    logic [15:0] wr2_data [16];
    logic [1:0]  wr2_addr [16];
    int          n_wr2 = 0;

    serial_capture #(.CLKS_PER_BIT(CLKS), .ADDR_W(8)) dut (
        .sysclk(sysclk), .reset(reset), .rx(rx), .clear(clear),
        .data_out(data_out), .we(we), .addr(addr), .full(full),
        .frame_err(frame_err), .busy(busy)
    );

    serial_capture #(.CLKS_PER_BIT(CLKS), .ADDR_W(2)) dut2 (
        .sysclk(sysclk), .reset(reset), .rx(rx2), .clear(clear2),
        .data_out(data_out2), .we(we2), .addr(addr2), .full(full2),
        .frame_err(frame_err2), .busy(busy2)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (we && n_wr < 16) begin
            wr_data[n_wr] = data_out;
            wr_addr[n_wr] = addr;
            wr_cyc[n_wr]  = cyc;
        end
        if (we) n_wr++;
        if (we2 && n_wr2 < 16) begin
            wr2_data[n_wr2] = data_out2;
            wr2_addr[n_wr2] = addr2;
        end
        if (we2) n_wr2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drive_bit(input logic v, input bit second);
        if (second) rx2 = v;
        else rx = v;
        repeat (CLKS) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit second);
        t_start = cyc;
        drive_bit(1'b0, second);
        for (int i = 0; i < 8; i++) drive_bit(b[i], second);
        drive_bit(stop_bit, second);
    endtask

    task automatic pulse_clear(input bit second);
        if (second) clear2 = 1'b1;
        else clear = 1'b1;
        @(negedge sysclk);
        clear  = 1'b0;
        clear2 = 1'b0;
    endtask

    initial begin
        logic [7:0] msg [3];
        msg[0] = 8'h48; msg[1] = 8'h49; msg[2] = 8'h0D;
        rx = 1'b1; rx2 = 1'b1; clear = 1'b0; clear2 = 1'b0; reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        check("rst_data", data_out, 16'h0000);
        check("rst_flags", {we, full, frame_err, busy}, 4'b0000);
        check("rst_addr", addr, 8'd0);

        // Single byte with latency check
        send_byte(8'h41, 1'b1, 1'b0);
        check("a_nwr", n_wr, 1);
        check("a_data", wr_data[0], 16'h8041);
        check("a_waddr", wr_addr[0], 8'd0);
        check("a_lat", wr_cyc[0] - t_start, 155);
        check("a_addr", addr, 8'd1);
        check("a_ferr", frame_err, 1'b0);

        // Back-to-back string
        pulse_clear(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(msg[i], 1'b1, 1'b0);
            check("hi_busy_gap", busy, 1'b0);
        end
        check("hi_nwr", n_wr, 4);
        check("hi_d0", {wr_data[1], wr_addr[1]}, {16'h8048, 8'd0});
        check("hi_d1", {wr_data[2], wr_addr[2]}, {16'h8049, 8'd1});
        check("hi_d2", {wr_data[3], wr_addr[3]}, {16'h800D, 8'd2});
        check("hi_addr", addr, 8'd3);

        // Glitch rejected by START
        pulse_clear(1'b0);
        rx = 1'b0;
        repeat (3) @(negedge sysclk);
        check("gl_busy", busy, 1'b1);
        rx = 1'b1;
        repeat (30) @(negedge sysclk);
        check("gl_state", {busy, frame_err}, 2'b00);
        check("gl_nwr", n_wr, 4);

        // Framing error with line held low
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge sysclk);
        check("fe_err", frame_err, 1'b1);
        check("fe_break", busy, 1'b1);
        check("fe_nwr", n_wr, 4);
        rx = 1'b1;
        repeat (5) @(negedge sysclk);
        check("fe_idle", busy, 1'b0);
        send_byte(8'h31, 1'b1, 1'b0);
        check("fe_next", {wr_data[4], wr_addr[4]}, {16'h8031, 8'd0});
        check("fe_sticky", frame_err, 1'b1);

        // Buffer full on the 2-bit address instance
        pulse_clear(1'b1);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 1'b1);
            if (i == 4) check("full_set", {full2, addr2}, {1'b1, 2'd0});
        end
        check("full_nwr", n_wr2, 4);
        check("full_w0", {wr2_data[0], wr2_addr[0]}, {16'h8001, 2'd0});
        check("full_w3", {wr2_data[3], wr2_addr[3]}, {16'h8004, 2'd3});
        check("full_hold", {full2, addr2, data_out2}, {1'b1, 2'd0, 16'h8004});
        pulse_clear(1'b1);
        check("full_clr", {full2, frame_err2, addr2}, {1'b0, 1'b0, 2'd0});

        // Reset mid-frame
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 1'b0);
        rx = 1'b1;
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        check("mr_out", {data_out, addr, full, frame_err, busy, we}, {16'h0, 8'd0, 4'b0000});
        repeat (200) @(negedge sysclk);
        check("mr_nwr", n_wr, 5);
        send_byte(8'h7A, 1'b1, 1'b0);
        check("mr_next", {wr_data[5], wr_addr[5]}, {16'h807A, 8'd0});

        // Clear mid-frame keeps data_out
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        rx = 1'b1;
        pulse_clear(1'b0);
        check("mc_out", {data_out, addr, full, frame_err, busy, we}, {16'h807A, 8'd0, 4'b0000});
        repeat (200) @(negedge sysclk);
        check("mc_nwr", n_wr, 6);
        send_byte(8'h42, 1'b1, 1'b0);
        check("mc_next", {wr_data[6], wr_addr[6]}, {16'h8042, 8'd0});
        check("mc_total", n_wr, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_capture.md
# serial_capture

Upstream receive stage for the word board: deserialises 8N1 ASCII arriving on the serial input line and writes each received byte into the character RAM as a tagged 16-bit word (bit 15 = valid). The RAM is then read back by the word board for retransmission. The block owns the RAM write port: data, write strobe and an auto-incrementing write address. It also reports buffer-full and framing-error status.

## Interface
- CLKS_PER_BIT, default 10416: sysclk cycles per bit (9600 baud at 100 MHz); must be >= 4
- ADDR_W, default 8: RAM address width; depth = 2**ADDR_W
- sysclk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- rx  in  1  asynchronous serial line; idle high; 8N1, LSB first
- clear  in  1  one-cycle pulse: aborts any frame in progress, zeroes addr, clears full and frame_err
- data_out  out  16  {1'b1, 7'b0, byte}; held until the next write
- we  out  1  one-cycle RAM write strobe
- addr  out  ADDR_W  RAM write address for the current/next write
- full  out  1  set after a write to address 2**ADDR_W-1
- frame_err  out  1  sticky; set when a stop bit samples 0
- busy  out  1  high in any state other than IDLE

## Operation
- rx passes through a 2-flop synchroniser (both flops reset to 1); rx_s is the second-flop output. All decisions use rx_s only.
- Let H = CLKS_PER_BIT/2 (floor) and N = CLKS_PER_BIT. One cycle counter, wide enough for N-1, plus a 3-bit bit index and an 8-bit shift register.
- States:
  - IDLE: when rx_s==0, go to START with the counter at 0. The first such cycle is T0.
  - START: wait until T0+H, then sample. rx_s==1 means a glitch: return to IDLE with no status change. rx_s==0 means go to DATA.
  - DATA: sample at T0+H+k*N for k=1..8 and shift in LSB first. After k=8, go to STOP.
  - STOP: sample at T0+H+9N. rx_s==1 means go to WRITE. rx_s==0 means set frame_err, make no write, and go to BREAK.
  - WRITE: one cycle. If full==0, assert we with data_out = {1'b1, 7'b0, byte}. In all cases return to IDLE.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Address:
  - addr increments in the cycle after we.
  - A write to 2**ADDR_W-1 sets full; addr then wraps to 0.
  - While full, frames are still received and checked, but we is suppressed and addr does not change.
- clear takes priority over every other event in the same cycle. It forces IDLE, suppresses we in that cycle, sets addr=0, and clears full and frame_err. data_out is unchanged.
- reset has the same effect as clear and additionally sets data_out=0.

## Timing
- Reset values: data_out=16'h0000, we=0, addr=0, full=0, frame_err=0, busy=0. Internal state is IDLE and the synchroniser flops are 1.
- The rx falling edge reaches rx_s 2 cycles later.
- we is asserted in cycle T0+H+9N+1, exactly one cycle wide. data_out and addr are valid in that same cycle.
- frame_err rises in cycle T0+H+9N+1.
- busy rises at T0+1 and falls on return to IDLE.
- Back-to-back frames are accepted: IDLE is re-entered by T0+H+9N+2, before the earliest possible next start edge (at T0+10N for a nominal sender).
- Reset or clear mid-frame discards the partial byte; nothing is written.

## Test plan
- CLKS_PER_BIT=16. Send 0x41 with stop=1 -> we pulses once at T0+153 with data_out=16'h8041 and addr=0; addr=1 the next cycle; frame_err=0.
- Send "HI\r" back-to-back -> three writes: 16'h8048 @0, 16'h8049 @1, 16'h800D @2; final addr=3; busy drops between frames.
- Pulse rx low for 3 cycles (glitch) -> START rejects it; no we, frame_err=0, state back to IDLE.
- Send 0x55 with stop=0, holding rx low for 40 cycles -> frame_err=1, no we, stays in BREAK until rx is high. A following valid 0x31 then writes 16'h8031 @0.
- ADDR_W=2, send 5 bytes -> writes at addresses 0..3 only; full=1 after the 4th write; addr=0; the 5th byte produces no we. Pulse clear -> full=0, frame_err=0, addr=0.
- Assert reset (and, separately, clear) at bit 4 of a frame -> all outputs return to reset values (clear leaves data_out unchanged); no write occurs. The next full frame is captured correctly at addr 0.
